led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 8, number of pattern slots (power of 2, 2..16).
REQ-002 Parameter PERIOD_W, default 24, width of step-period counter.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 s_address  input  4  CSR word address.
REQ-006 s_chipselect  input  1  CSR select.
REQ-007 s_write_n  input  1  CSR write strobe, active-low.
REQ-008 s_writedata  input  32  CSR write data.
REQ-009 s_readdata  output  32  CSR read data, zero-wait-state, combinational from s_address.
REQ-010 m_address  output  2  PIO word address; always 0.
REQ-011 m_chipselect  output  1  PIO select; high only during a PIO write cycle.
REQ-012 m_write_n  output  1  PIO write strobe, active-low.
REQ-013 m_writedata  output  32  PIO data; 0 when m_chipselect low.

Function
REQ-014 CSR write occurs on a cycle with s_chipselect=1 and s_write_n=0; writes to unmapped addresses are ignored; reads of unmapped addresses return 0.
REQ-015 CSR map: 0 CTRL (bit0 ENABLE, bit1 ONESHOT, bit2 RESTART write-1 self-clearing, reads 0); 1 STATUS read-only (bit0 RUNNING, bit1 DONE, bits[7:4] current step); 2 PERIOD [PERIOD_W-1:0]; 3 LENGTH [4:0]; 4 DIRECT [31:0]; 8..8+NUM_STEPS-1 PATTERN[i].
REQ-016 FSM states: IDLE, WRITE, WAIT, DONE.
REQ-017 IDLE -> WRITE on the cycle after a CSR write leaving ENABLE=1 (from 0) or RESTART=1; step set to 0, DONE cleared.
REQ-018 WRITE lasts exactly one cycle: m_chipselect=1, m_write_n=0, m_address=0, m_writedata=PATTERN[step] as registered at the start of that cycle.
REQ-019 Consecutive sequencer writes are spaced exactly P cycles apart, P = max(PERIOD, 2); WAIT holds P-1 cycles.
REQ-020 Effective length L = LENGTH clamped to 1..NUM_STEPS (0 -> 1, >NUM_STEPS -> NUM_STEPS).
REQ-021 WAIT end, ONESHOT=0: step = (step = L-1) ? 0 : step+1, go to WRITE.
REQ-022 WAIT end, ONESHOT=1 and step = L-1: go to DONE; DONE clears ENABLE, sets DONE bit, returns to IDLE next cycle.
REQ-023 PERIOD/LENGTH/ONESHOT changes during a run take effect at the next WAIT evaluation; a LENGTH reduction with step >= new L wraps step to 0 at the next advance.
REQ-024 CSR write clearing ENABLE while running: FSM to IDLE next cycle, no further PIO writes, a WRITE in the same cycle completes; PIO retains last value.
REQ-025 RESTART while running: step=0, counter cleared, WRITE next cycle; RESTART with ENABLE=0 performs one pass from step 0 as if ENABLE were set.
REQ-026 DIRECT write while IDLE: one PIO write of the new DIRECT value on the next cycle; while running the DIRECT register updates but no PIO write is issued.
REQ-027 CSR write to PATTERN[step] in the same cycle as WRITE: PIO receives old value, new value used on the next visit.
REQ-028 RUNNING = 1 in WRITE and WAIT, else 0.

Reset
REQ-029 reset_n low asynchronously forces: FSM IDLE, step 0, counter 0, CTRL 0, DONE 0, PERIOD 1_000_000, LENGTH NUM_STEPS, DIRECT 0, all PATTERN 0.
REQ-030 During reset: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, s_readdata reflects reset register values.
REQ-031 reset_n asserted mid-WRITE aborts the strobe immediately; no PIO write after deassertion until a new start condition.

Verification
REQ-032 PATTERN[0..3]=1,2,4,8, LENGTH=4, PERIOD=5, CTRL=1 -> PIO writes 1,2,4,8,1,... exactly 5 cycles apart, first write one cycle after the CTRL write.
REQ-033 Same setup, CTRL=3 (oneshot) -> writes 1,2,4,8 then DONE=1, ENABLE=0, RUNNING=0, no fifth write.
REQ-034 PERIOD=0 and PERIOD=1 -> write spacing 2 cycles; LENGTH=0 -> only PATTERN[0] repeats; LENGTH=31 -> all NUM_STEPS slots cycle.
REQ-035 IDLE, DIRECT=0xA5A5_0001 -> single PIO write of 0xA5A5_0001 next cycle; repeat while running -> no PIO write, DIRECT reads back new value.
REQ-036 Running, write CTRL=0 during WAIT -> zero further writes; then RESTART -> write of PATTERN[0] next cycle.
REQ-037 reset_n pulsed low during WRITE -> strobe deasserts asynchronously, all CSRs read reset values, outputs idle until re-enabled.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer.
// A CSR slave holds up to NUM_STEPS pattern words. Once started, the
// sequencer pushes one pattern word per period to an LED PIO through a
// single-cycle master write. It loops, or stops after one pass in one-shot mode.
// The DIRECT register gives software a one-off PIO write while the sequencer is idle.
module led_pattern_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int PERIOD_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(1_000_000);
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(2);
    localparam logic [4:0]          LEN_MAX    = 5'(NUM_STEPS);

    // CSR word addresses
    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_PERIOD = 4'd2;
    localparam logic [3:0] A_LENGTH = 4'd3;
    localparam logic [3:0] A_DIRECT = 4'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q,       state_d;
    logic [SW-1:0]       step_q,        step_d;
    logic [PERIOD_W-1:0] cnt_q,         cnt_d;
    logic                enable_q,      enable_d;
    logic                oneshot_q,     oneshot_d;
    // Single pass requested by RESTART while ENABLE is clear.
    logic                pass_q,        pass_d;
    logic                done_q,        done_d;
    logic [PERIOD_W-1:0] period_q,      period_d;
    logic [4:0]          length_q,      length_d;
    logic [31:0]         direct_q,      direct_d;
    // DIRECT was written while idle; drive it out on the next cycle.
    logic                direct_pend_q, direct_pend_d;
    logic [31:0]         pattern_q [NUM_STEPS];
    logic [31:0]         pattern_d [NUM_STEPS];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic csr_wr;
    logic wr_ctrl, wr_period, wr_length, wr_direct;
    logic running;
    logic start, stop;
    logic oneshot_eff;
    logic [4:0] len_eff;
    logic [4:0] last_step;
    logic at_last;
    logic [PERIOD_W-1:0] period_eff;
    logic wait_done;

    assign csr_wr    = s_chipselect && !s_write_n;
    assign wr_ctrl   = csr_wr && (s_address == A_CTRL);
    assign wr_period = csr_wr && (s_address == A_PERIOD);
    assign wr_length = csr_wr && (s_address == A_LENGTH);
    assign wr_direct = csr_wr && (s_address == A_DIRECT);

    assign running = (state_q == ST_WRITE) || (state_q == ST_WAIT);

    // RESTART always (re)starts; ENABLE starts only on a 0->1 change.
    assign start = wr_ctrl && (s_writedata[2] || (s_writedata[0] && !enable_q));
    // Clearing ENABLE without RESTART halts an active run.
    assign stop  = wr_ctrl && !s_writedata[0] && !s_writedata[2] && running;

    assign oneshot_eff = oneshot_q || pass_q;

    // Length clamp keeps the step index inside the populated slots.
    always_comb begin
        len_eff = length_q;
        if (length_q == 5'd0)
            len_eff = 5'd1;
        else if (length_q > LEN_MAX)
            len_eff = LEN_MAX;
    end

    assign last_step = len_eff - 5'd1;
    // >= so that a shortened LENGTH wraps a step already past the new end.
    assign at_last   = 5'(step_q) >= last_step;

    // Period floor of 2 leaves room for at least one WAIT cycle.
    assign period_eff = (period_q < PERIOD_MIN) ? PERIOD_MIN : period_q;
    // >= so that a shortened PERIOD cannot strand the counter past the end.
    assign wait_done  = cnt_q >= (period_eff - PERIOD_MIN);

    // ------------------------------------------------------------------
    // Next-state: CSR updates and sequencer FSM
    // ------------------------------------------------------------------
    // Next-state logic for the CSRs and the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        enable_d      = enable_q;
        oneshot_d     = oneshot_q;
        pass_d        = pass_q;
        done_d        = done_q;
        period_d      = period_q;
        length_d      = length_q;
        direct_d      = direct_q;
        direct_pend_d = 1'b0;

        if (wr_ctrl) begin
            enable_d  = s_writedata[0];
            oneshot_d = s_writedata[1];
            pass_d    = s_writedata[2] && !s_writedata[0];
        end
        if (wr_period)
            period_d = s_writedata[PERIOD_W-1:0];
        if (wr_length)
            length_d = s_writedata[4:0];
        if (wr_direct) begin
            direct_d      = s_writedata;
            // Only an idle sequencer hands the PIO to DIRECT.
            direct_pend_d = !running;
        end

        if (start) begin
            state_d = ST_WRITE;
            step_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WRITE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        cnt_d = '0;
                        if (oneshot_eff && at_last) begin
                            state_d  = ST_DONE;
                            enable_d = 1'b0;
                            pass_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            state_d = ST_WRITE;
                            step_d  = at_last ? '0 : step_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Pattern slot writes; slots sit at word address 8 upward (only the
    // first eight are reachable through the 4-bit address).
    always_comb begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            pattern_d[i] = pattern_q[i];
            if (csr_wr && ({1'b0, s_address} == 5'(8 + i)))
                pattern_d[i] = s_writedata;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control, status and sequencing registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            oneshot_q     <= 1'b0;
            pass_q        <= 1'b0;
            done_q        <= 1'b0;
            period_q      <= PERIOD_RST;
            length_q      <= LEN_MAX;
            direct_q      <= '0;
            direct_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            oneshot_q     <= oneshot_d;
            pass_q        <= pass_d;
            done_q        <= done_d;
            period_q      <= period_d;
            length_q      <= length_d;
            direct_q      <= direct_d;
            direct_pend_q <= direct_pend_d;
        end
    end

    // Pattern storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STEPS; i++)
                pattern_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STEPS; i++)
                pattern_q[i] <= pattern_d[i];
        end
    end

    // ------------------------------------------------------------------
    // PIO master: decoded straight from state so reset drops the strobe at once
    // ------------------------------------------------------------------
    logic pio_seq, pio_direct;

    assign pio_seq    = (state_q == ST_WRITE);
    assign pio_direct = direct_pend_q && (state_q == ST_IDLE);

    // Drive the single-cycle PIO write for a sequencer step or a DIRECT update.
    always_comb begin
        m_address    = 2'd0;
        m_chipselect = pio_seq || pio_direct;
        m_write_n    = !(pio_seq || pio_direct);
        m_writedata  = '0;
        if (pio_seq)
            m_writedata = pattern_q[step_q];
        else if (pio_direct)
            m_writedata = direct_q;
    end

    // ------------------------------------------------------------------
    // CSR read mux (zero wait state)
    // ------------------------------------------------------------------
    // Combinational read-back; RESTART and unmapped words read as zero.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            A_CTRL:   s_readdata = {30'd0, oneshot_q, enable_q};
            A_STATUS: s_readdata = {24'd0, 4'(step_q), 2'b00, done_q, running};
            A_PERIOD: s_readdata = 32'(period_q);
            A_LENGTH: s_readdata = {27'd0, length_q};
            A_DIRECT: s_readdata = direct_q;
            default:  s_readdata = '0;
        endcase
        for (int i = 0; i < NUM_STEPS; i++) begin
            if ({1'b0, s_address} == 5'(8 + i))
                s_readdata = pattern_q[i];
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: each scenario pushes the PIO
// writes it expects (value and cycle); a monitor pops them as they appear.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    led_pattern_sequencer #(.NUM_STEPS(8), .PERIOD_W(24)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] pat_m [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] d, input int unsigned at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Advance to 1 time unit after the next rising edge(s).
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick(1);
    endtask

    // One-cycle CSR write; w is the cycle in which the write is presented.
    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d, output int unsigned w);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        w            = cyc;
        tick(1);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic check_reset_vals(input string tag);
        logic [31:0] r;
        csr_rd(4'd0, r);  chk({tag, "_ctrl"},   r, 32'h0);
        csr_rd(4'd1, r);  chk({tag, "_status"}, r, 32'h0);
        csr_rd(4'd2, r);  chk({tag, "_period"}, r, 32'd1_000_000);
        csr_rd(4'd3, r);  chk({tag, "_length"}, r, 32'd8);
        csr_rd(4'd4, r);  chk({tag, "_direct"}, r, 32'h0);
        csr_rd(4'd8, r);  chk({tag, "_pat0"},   r, 32'h0);
    endtask

    // PIO monitor: idle bus must be quiet; every strobe must match the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic has;
        if (m_chipselect) begin
            chk("pio_wr_n", {31'd0, m_write_n}, 32'd0);
            chk("pio_addr", {30'd0, m_address}, 32'd0);
            has = (sb.size() != 0);
            chk("pio_expected", {31'd0, has}, 32'd1);
            if (has) begin
                e = sb.pop_front();
                chk("pio_data", m_writedata, e.data);
                chk("pio_cycle", cyc, e.cyc);
            end
        end else begin
            chk("idle_wr_n", {31'd0, m_write_n}, 32'd1);
            chk("idle_data", m_writedata, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned w, d;
        logic [31:0] r;

        pat_m = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80};

        // Reset values visible while reset is held.
        tick(2);
        chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick(2);

        // Unmapped address: write ignored, reads zero.
        csr_wr(4'd5, 32'hFFFF_FFFF, d);
        csr_rd(4'd5, r);  chk("unmapped_rd", r, 32'h0);

        // Looping run, LENGTH=4, PERIOD=5; PATTERN[0] rewritten during its WRITE.
        for (int i = 0; i < 4; i++) csr_wr(4'(8 + i), pat_m[i], d);
        csr_wr(4'd3, 32'd4, d);
        csr_wr(4'd2, 32'd5, d);
        csr_rd(4'd2, r);  chk("period_rd", r, 32'd5);
        csr_wr(4'd0, 32'd1, w);
        push(32'h1, w + 1);  push(32'h2, w + 6);  push(32'h4, w + 11);
        push(32'h8, w + 16); push(32'h99, w + 21); push(32'h2, w + 26);
        csr_wr(4'd8, 32'h99, d);
        wait_until(w + 28);
        csr_wr(4'd0, 32'd0, d);
        tick(12);
        csr_rd(4'd1, r);  chk("stop_running", r & 32'h1, 32'h0);
        chk("sb_loop", sb.size(), 0);
        csr_wr(4'd8, 32'h1, d);

        // RESTART with ENABLE clear: one pass from step 0.
        csr_wr(4'd0, 32'd4, w);
        push(32'h1, w + 1); push(32'h2, w + 6); push(32'h4, w + 11); push(32'h8, w + 16);
        wait_until(w + 30);
        csr_rd(4'd1, r);  chk("restart_status", r, 32'h32);
        csr_rd(4'd0, r);  chk("restart_ctrl", r, 32'h0);
        chk("sb_restart", sb.size(), 0);

        // One-shot: four writes then DONE, ENABLE cleared.
        csr_wr(4'd0, 32'd3, w);
        push(32'h1, w + 1); push(32'h2, w + 6); push(32'h4, w + 11); push(32'h8, w + 16);
        wait_until(w + 3);
        csr_rd(4'd1, r);  chk("oneshot_mid_status", r, 32'h01);
        wait_until(w + 30);
        csr_rd(4'd1, r);  chk("oneshot_status", r, 32'h32);
        csr_rd(4'd0, r);  chk("oneshot_ctrl", r, 32'h2);
        chk("sb_oneshot", sb.size(), 0);

        // PERIOD=0 clamps to 2; LENGTH=0 repeats PATTERN[0].
        csr_wr(4'd2, 32'd0, d);
        csr_wr(4'd3, 32'd0, d);
        csr_wr(4'd0, 32'd1, w);
        for (int k = 0; k < 4; k++) push(pat_m[0], w + 1 + 2 * k);
        wait_until(w + 8);
        csr_wr(4'd0, 32'd0, d);
        tick(8);
        chk("sb_len0", sb.size(), 0);

        // PERIOD=1 clamps to 2; LENGTH=31 clamps to all 8 slots.
        csr_wr(4'd2, 32'd1, d);
        csr_wr(4'd3, 32'd31, d);
        for (int i = 4; i < 8; i++) csr_wr(4'(8 + i), pat_m[i], d);
        csr_wr(4'd0, 32'd1, w);
        for (int k = 0; k < 9; k++) push(pat_m[k % 8], w + 1 + 2 * k);
        wait_until(w + 18);
        csr_wr(4'd0, 32'd0, d);
        tick(8);
        csr_rd(4'd3, r);  chk("length_rd", r, 32'd31);
        chk("sb_len31", sb.size(), 0);

        // DIRECT while idle drives the PIO once; while running it only updates.
        csr_wr(4'd2, 32'd5, d);
        csr_wr(4'd3, 32'd4, d);
        csr_wr(4'd4, 32'hA5A5_0001, w);
        push(32'hA5A5_0001, w + 1);
        tick(3);
        csr_wr(4'd0, 32'd1, w);
        push(32'h1, w + 1); push(32'h2, w + 6);
        wait_until(w + 3);
        csr_wr(4'd4, 32'h1234_5678, d);
        csr_rd(4'd4, r);  chk("direct_rd", r, 32'h1234_5678);
        wait_until(w + 8);
        csr_wr(4'd0, 32'd0, d);
        tick(8);
        chk("sb_direct", sb.size(), 0);

        // Reset pulse in the middle of a WRITE cycle.
        csr_wr(4'd0, 32'd1, w);
        chk("pre_rst_cs", {31'd0, m_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_async_wn", {31'd0, m_write_n}, 32'd1);
        check_reset_vals("midrst");
        tick(2);
        reset_n = 1'b1;
        tick(20);
        csr_rd(4'd1, r);  chk("post_rst_status", r, 32'h0);
        chk("sb_reset", sb.size(), 0);

        tick(2);
        chk("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
